// File: rtl/fifo_uart_tx.sv
// UART 8N1/8N2 transmitter that drains a synchronous FIFO through its read port.
// One pop per frame; back-to-back frames are separated by the FETCH/LOAD cycles only.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift_reg;
   logic              launch;
   logic              baud_end;

   always_comb begin
      launch   = tx_enable & ~fifo_empty;
      baud_end = (baud_cnt == BAUD_LAST);
   end

   // Outputs are assigned alongside the state they belong to, so they track state exactly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         fifo_rd_en <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         fifo_rd_en <= 1'b0;
         tx_done    <= 1'b0;
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (launch) begin
                  state      <= FETCH;
                  fifo_rd_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            FETCH: begin
               state <= LOAD;
            end
            LOAD: begin
               shift_reg <= fifo_data;
               baud_cnt  <= '0;
               tx        <= 1'b0;
               state     <= START;
            end
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt  <= '0;
                  shift_reg <= shift_reg >> 1;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     tx      <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               // Registered pulse: raised one cycle early so it lands on the last stop cycle.
               if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE)
                  tx_done <= 1'b1;
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     if (launch) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
